// File: rtl/image_crop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_crop_pkg
// Description : Shared constants and helpers for the image crop/window stage.
//               Mode encodings, default window bounds, channel pack/unpack.
// Revision    : 1.0 - initial release
// ============================================================================
package image_crop_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BYPASS = 2'd0;
  localparam mode_t MODE_BLANK  = 2'd1;
  localparam mode_t MODE_BORDER = 2'd2;
  localparam mode_t MODE_DROP   = 2'd3;

  localparam int DEFAULT_H_START = 256;
  localparam int DEFAULT_H_END   = 639;
  localparam int DEFAULT_V_START = 0;
  localparam int DEFAULT_V_END   = 479;

  // Widest pixel word the helpers below can handle.
  localparam int PIX_MAX_W = 64;

  // Extract channel k (w bits wide) from a packed pixel.
  function automatic logic [PIX_MAX_W-1:0] ch_get(input logic [PIX_MAX_W-1:0] pix,
                                                  input int k, input int w);
    return (pix >> (k * w)) & ((64'd1 << w) - 64'd1);
  endfunction

  // Replace channel k (w bits wide) of a packed pixel with val.
  function automatic logic [PIX_MAX_W-1:0] ch_put(input logic [PIX_MAX_W-1:0] pix,
                                                  input int k, input int w,
                                                  input logic [PIX_MAX_W-1:0] val);
    logic [PIX_MAX_W-1:0] mask;
    mask = ((64'd1 << w) - 64'd1) << (k * w);
    return (pix & ~mask) | ((val << (k * w)) & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crop_window_cmp.sv
`default_nettype none
// ============================================================================
// Module      : crop_window_cmp
// Description : Combinational window test. Reports whether a coordinate lies
//               inside an inclusive rectangle and whether it sits on its edge.
//               A start bound above its end bound yields an empty window.
// Revision    : 1.0 - initial release
// ============================================================================
module crop_window_cmp #(
  parameter int CNT_W = 13
) (
  input  logic [CNT_W-1:0] i_h_cont,
  input  logic [CNT_W-1:0] i_v_cont,
  input  logic [CNT_W-1:0] i_h_start,
  input  logic [CNT_W-1:0] i_h_end,
  input  logic [CNT_W-1:0] i_v_start,
  input  logic [CNT_W-1:0] i_v_end,
  output logic             o_in_win,
  output logic             o_on_edge
);

  logic w_h_in;
  logic w_v_in;

  // Inclusive range test per axis; the edge flag only counts inside pixels.
  always_comb begin
    w_h_in    = (i_h_cont >= i_h_start) && (i_h_cont <= i_h_end);
    w_v_in    = (i_v_cont >= i_v_start) && (i_v_cont <= i_v_end);
    o_in_win  = w_h_in && w_v_in;
    o_on_edge = o_in_win && ((i_h_cont == i_h_start) || (i_h_cont == i_h_end) ||
                             (i_v_cont == i_v_start) || (i_v_cont == i_v_end));
  end

endmodule
`default_nettype wire

// File: rtl/image_crop_window.sv
`default_nettype none
// ============================================================================
// Module      : image_crop_window
// Description : Two-stage crop/window stage. Pixels are passed, blanked,
//               outlined or dropped relative to a double-buffered window that
//               is swapped in at frame start. Counts in-window pixels/frame.
// Revision    : 1.0 - initial release
// ============================================================================
module image_crop_window
  import image_crop_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int NCH         = 3,
  parameter int CNT_W       = 13,
  parameter int DEF_H_START = DEFAULT_H_START,
  parameter int DEF_H_END   = DEFAULT_H_END,
  parameter int DEF_V_START = DEFAULT_V_START,
  parameter int DEF_V_END   = DEFAULT_V_END
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iDVAL,
  input  logic [CNT_W-1:0]        iH_Cont,
  input  logic [CNT_W-1:0]        iV_Cont,
  input  logic [NCH*DATA_W-1:0]   iDATA,
  input  logic                    iCFG_WE,
  input  logic [CNT_W-1:0]        iH_START,
  input  logic [CNT_W-1:0]        iH_END,
  input  logic [CNT_W-1:0]        iV_START,
  input  logic [CNT_W-1:0]        iV_END,
  input  logic [1:0]              iMODE,
  input  logic [NCH*DATA_W-1:0]   iFILL,
  output logic [NCH*DATA_W-1:0]   oDATA,
  output logic                    oDVAL,
  output logic                    oIN_WIN,
  output logic                    oCFG_PEND,
  output logic [2*CNT_W-1:0]      oWIN_CNT
);

  localparam int PIX_W  = NCH * DATA_W;
  localparam int WCNT_W = 2 * CNT_W;

  typedef struct packed {
    logic [CNT_W-1:0] h_start;
    logic [CNT_W-1:0] h_end;
    logic [CNT_W-1:0] v_start;
    logic [CNT_W-1:0] v_end;
    mode_t            mode;
    logic [PIX_W-1:0] fill;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    h_start: CNT_W'(DEF_H_START),
    h_end:   CNT_W'(DEF_H_END),
    v_start: CNT_W'(DEF_V_START),
    v_end:   CNT_W'(DEF_V_END),
    mode:    MODE_BLANK,
    fill:    '0
  };

  // Configuration double buffer and status
  cfg_t              pend_cfg_q, pend_cfg_d;
  cfg_t              act_cfg_q,  act_cfg_d;
  logic              cfg_pend_q, cfg_pend_d;
  logic [WCNT_W-1:0] pix_cnt_q,  pix_cnt_d;
  logic [WCNT_W-1:0] win_cnt_q,  win_cnt_d;

  // Stage 1
  logic [PIX_W-1:0]  s1_data_q,    s1_data_d;
  logic              s1_dval_q,    s1_dval_d;
  logic              s1_in_win_q,  s1_in_win_d;
  logic              s1_on_edge_q, s1_on_edge_d;
  mode_t             s1_mode_q,    s1_mode_d;
  logic [PIX_W-1:0]  s1_fill_q,    s1_fill_d;

  // Stage 2 (outputs)
  logic [PIX_W-1:0]  out_data_q,   out_data_d;
  logic              out_dval_q,   out_dval_d;
  logic              out_in_win_q, out_in_win_d;

  logic              w_fs;
  logic              w_hit;
  logic              w_in_win;
  logic              w_on_edge;
  cfg_t              w_use_cfg;

  // Frame start selects the pending config so the FS pixel sees the new window.
  always_comb begin
    w_fs      = iDVAL && (iH_Cont == '0) && (iV_Cont == '0);
    w_use_cfg = w_fs ? pend_cfg_q : act_cfg_q;
  end

  crop_window_cmp #(
    .CNT_W (CNT_W)
  ) u_cmp (
    .i_h_cont  (iH_Cont),
    .i_v_cont  (iV_Cont),
    .i_h_start (w_use_cfg.h_start),
    .i_h_end   (w_use_cfg.h_end),
    .i_v_start (w_use_cfg.v_start),
    .i_v_end   (w_use_cfg.v_end),
    .o_in_win  (w_in_win),
    .o_on_edge (w_on_edge)
  );

  // Pending/active config: a write landing on FS goes to pending after the swap.
  always_comb begin
    pend_cfg_d = pend_cfg_q;
    if (iCFG_WE) begin
      pend_cfg_d = '{h_start: iH_START, h_end: iH_END, v_start: iV_START,
                     v_end: iV_END, mode: iMODE, fill: iFILL};
    end
    act_cfg_d  = w_fs ? pend_cfg_q : act_cfg_q;
    cfg_pend_d = iCFG_WE ? 1'b1 : (w_fs ? 1'b0 : cfg_pend_q);
  end

  // Saturating in-window counter, snapshotted and restarted at frame start.
  always_comb begin
    w_hit     = iDVAL && w_in_win;
    pix_cnt_d = pix_cnt_q;
    win_cnt_d = win_cnt_q;
    if (w_fs) begin
      win_cnt_d = pix_cnt_q;
      pix_cnt_d = {{(WCNT_W-1){1'b0}}, w_hit};
    end else if (w_hit && (pix_cnt_q != '1)) begin
      pix_cnt_d = pix_cnt_q + WCNT_W'(1);
    end
  end

  // Stage 1 captures the pixel with its compare flags and governing mode/fill.
  always_comb begin
    s1_data_d    = iDATA;
    s1_dval_d    = iDVAL;
    s1_in_win_d  = w_in_win;
    s1_on_edge_d = w_on_edge;
    s1_mode_d    = w_use_cfg.mode;
    s1_fill_d    = w_use_cfg.fill;
  end

  // Stage 2 applies the mode action; invalid output slots are forced to zero.
  always_comb begin
    out_dval_d = s1_dval_q;
    out_data_d = s1_data_q;
    case (s1_mode_q)
      MODE_BLANK:  if (!s1_in_win_q)  out_data_d = s1_fill_q;
      MODE_BORDER: if (s1_on_edge_q)  out_data_d = s1_fill_q;
      MODE_DROP:   if (!s1_in_win_q)  out_dval_d = 1'b0;
      default:     out_data_d = s1_data_q;
    endcase
    out_in_win_d = out_dval_d && s1_in_win_q;
    if (!out_dval_d) begin
      out_data_d = '0;
    end
  end

  // All state registers; reset flushes the pipeline immediately.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pend_cfg_q   <= CFG_RST;
      act_cfg_q    <= CFG_RST;
      cfg_pend_q   <= 1'b0;
      pix_cnt_q    <= '0;
      win_cnt_q    <= '0;
      s1_data_q    <= '0;
      s1_dval_q    <= 1'b0;
      s1_in_win_q  <= 1'b0;
      s1_on_edge_q <= 1'b0;
      s1_mode_q    <= MODE_BLANK;
      s1_fill_q    <= '0;
      out_data_q   <= '0;
      out_dval_q   <= 1'b0;
      out_in_win_q <= 1'b0;
    end else begin
      pend_cfg_q   <= pend_cfg_d;
      act_cfg_q    <= act_cfg_d;
      cfg_pend_q   <= cfg_pend_d;
      pix_cnt_q    <= pix_cnt_d;
      win_cnt_q    <= win_cnt_d;
      s1_data_q    <= s1_data_d;
      s1_dval_q    <= s1_dval_d;
      s1_in_win_q  <= s1_in_win_d;
      s1_on_edge_q <= s1_on_edge_d;
      s1_mode_q    <= s1_mode_d;
      s1_fill_q    <= s1_fill_d;
      out_data_q   <= out_data_d;
      out_dval_q   <= out_dval_d;
      out_in_win_q <= out_in_win_d;
    end
  end

  assign oDATA     = out_data_q;
  assign oDVAL     = out_dval_q;
  assign oIN_WIN   = out_in_win_q;
  assign oCFG_PEND = cfg_pend_q;
  assign oWIN_CNT  = win_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_image_crop_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_crop_window
// Description : Self-checking bench for image_crop_window: vector table,
//               hand-written frame sequences and randomized frames against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_crop_window;
  import image_crop_pkg::*;

  localparam int DW = 10;
  localparam int NCH = 3;
  localparam int CW = 13;
  localparam int PW = DW * NCH;
  localparam int WW = 2 * CW;
  localparam longint CNT_MAX = (64'd1 << WW) - 1;

  logic          iCLK, iRST, iDVAL, iCFG_WE;
  logic [CW-1:0] iH_Cont, iV_Cont, iH_START, iH_END, iV_START, iV_END;
  logic [PW-1:0] iDATA, iFILL;
  logic [1:0]    iMODE;
  logic [PW-1:0] oDATA;
  logic          oDVAL, oIN_WIN, oCFG_PEND;
  logic [WW-1:0] oWIN_CNT;

  image_crop_window #(
    .DATA_W(DW), .NCH(NCH), .CNT_W(CW),
    .DEF_H_START(256), .DEF_H_END(639), .DEF_V_START(0), .DEF_V_END(479)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iH_Cont(iH_Cont), .iV_Cont(iV_Cont),
    .iDATA(iDATA), .iCFG_WE(iCFG_WE), .iH_START(iH_START), .iH_END(iH_END),
    .iV_START(iV_START), .iV_END(iV_END), .iMODE(iMODE), .iFILL(iFILL),
    .oDATA(oDATA), .oDVAL(oDVAL), .oIN_WIN(oIN_WIN), .oCFG_PEND(oCFG_PEND),
    .oWIN_CNT(oWIN_CNT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Reference model state
  typedef struct { int hs; int he; int vs; int ve; int mode; logic [PW-1:0] fill; } mcfg_t;
  typedef struct { logic dval; logic inw; logic [PW-1:0] data; } mpix_t;

  mcfg_t  m_pend, m_act;
  bit     m_pflag;
  longint m_cnt, m_wcnt;
  mpix_t  m_s1;

  int n_checks = 0;
  int n_errors = 0;
  int seen_fill, seen_dval;
  logic [PW-1:0] tgt_fill;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] fill_all(input logic [DW-1:0] c);
    logic [63:0] p = '0;
    for (int k = 0; k < NCH; k++) p = ch_put(p, k, DW, 64'(c));
    return p[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] rand_pix();
    return PW'($urandom) & ~PW'(1);   // never all-ones
  endfunction

  task automatic model_reset();
    m_pend  = '{256, 639, 0, 479, 1, '0};
    m_act   = m_pend;
    m_pflag = 0;
    m_cnt   = 0;
    m_wcnt  = 0;
    m_s1    = '{1'b0, 1'b0, '0};
  endtask

  task automatic set_cfg(input int mode, input int hs, input int he, input int vs,
                         input int ve, input logic [PW-1:0] fill);
    iMODE = 2'(mode); iH_START = CW'(hs); iH_END = CW'(he);
    iV_START = CW'(vs); iV_END = CW'(ve); iFILL = fill;
  endtask

  // Apply one input cycle, advance the model, clock, and compare everything.
  task automatic step(input logic dv, input int h, input int v,
                      input logic [PW-1:0] d, input logic we);
    mcfg_t u;
    mpix_t e;
    bit    fs, inw, edg;
    iDVAL = dv; iH_Cont = CW'(h); iV_Cont = CW'(v); iDATA = d; iCFG_WE = we;
    fs = dv && (h == 0) && (v == 0);
    if (fs) u = m_pend; else u = m_act;
    inw = (h >= u.hs) && (h <= u.he) && (v >= u.vs) && (v <= u.ve);
    edg = inw && (h == u.hs || h == u.he || v == u.vs || v == u.ve);
    e.dval = dv;
    e.data = d;
    case (u.mode)
      1: if (!inw) e.data = u.fill;   // blank
      2: if (edg)  e.data = u.fill;   // border
      3: if (!inw) e.dval = 1'b0;     // drop
      default: ;
    endcase
    e.inw = e.dval && inw;
    if (!e.dval) e.data = '0;
    if (fs) begin
      m_act  = m_pend;
      m_wcnt = m_cnt;
      m_cnt  = (dv && inw) ? 1 : 0;
    end else if (dv && inw && m_cnt < CNT_MAX) begin
      m_cnt++;
    end
    if (we) begin
      m_pend  = '{int'(iH_START), int'(iH_END), int'(iV_START), int'(iV_END), int'(iMODE), iFILL};
      m_pflag = 1;
    end else if (fs) begin
      m_pflag = 0;
    end
    @(posedge iCLK);
    #1;
    iCFG_WE = 1'b0;
    chk("m_dval", 64'(oDVAL), 64'(m_s1.dval));
    chk("m_data", 64'(oDATA), 64'(m_s1.data));
    chk("m_inwin", 64'(oIN_WIN), 64'(m_s1.inw));
    chk("m_pend", 64'(oCFG_PEND), 64'(m_pflag));
    chk("m_wcnt", 64'(oWIN_CNT), 64'(m_wcnt));
    if (oDVAL === 1'b1) seen_dval++;
    if (oDVAL === 1'b1 && oDATA === tgt_fill) seen_fill++;
    m_s1 = e;
  endtask

  task automatic bubble();
    step(1'b0, 1, 1, '0, 1'b0);
  endtask

  task automatic frame(input int w, input int h, input int we_idx, input int start);
    for (int i = start; i < w * h; i++) step(1'b1, i % w, i / w, rand_pix(), 1'(i == we_idx));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    iRST = 1'b1; iDVAL = 1'b0; iCFG_WE = 1'b0;
    #1;
    chk("rst_dval", 64'(oDVAL), 64'd0);
    chk("rst_data", 64'(oDATA), 64'd0);
    chk("rst_inwin", 64'(oIN_WIN), 64'd0);
    chk("rst_pend", 64'(oCFG_PEND), 64'd0);
    chk("rst_wcnt", 64'(oWIN_CNT), 64'd0);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int mode; int hs; int he; int vs; int ve; logic [PW-1:0] fill;
    int h; int v; logic dv; logic [PW-1:0] d;
    logic xdv; logic xin; logic [PW-1:0] xd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [PW-1:0] f1, d1, d2, d3, all3ff;
    f1 = 30'h0ABCDEF; d1 = 30'h1234567; d2 = 30'h2468ACE; d3 = 30'h0135790;
    all3ff = fill_all(10'h3FF);
    tgt_fill = '1;
    seen_fill = 0; seen_dval = 0;
    iRST = 1'b0; iDVAL = 1'b0; iCFG_WE = 1'b0; iH_Cont = '0; iV_Cont = '0; iDATA = '0;
    set_cfg(0, 0, 0, 0, 0, '0);

    //        mode hs   he   vs ve   fill    h    v    dv d     xdv xin xd
    tbl[0]  = '{1, 256, 639, 0, 479, '0,     255, 10,  1, d1,   1,  0,  '0};
    tbl[1]  = '{1, 256, 639, 0, 479, '0,     256, 10,  1, d1,   1,  1,  d1};
    tbl[2]  = '{1, 256, 639, 0, 479, '0,     639, 479, 1, d2,   1,  1,  d2};
    tbl[3]  = '{1, 256, 639, 0, 479, f1,     640, 10,  1, d2,   1,  0,  f1};
    tbl[4]  = '{1, 256, 639, 0, 479, f1,     300, 480, 1, d1,   1,  0,  f1};
    tbl[5]  = '{2, 2,   5,   2, 5,   all3ff, 2,   3,   1, d1,   1,  1,  all3ff};
    tbl[6]  = '{2, 2,   5,   2, 5,   all3ff, 3,   3,   1, d1,   1,  1,  d1};
    tbl[7]  = '{2, 2,   5,   2, 5,   all3ff, 6,   3,   1, d2,   1,  0,  d2};
    tbl[8]  = '{2, 2,   5,   2, 5,   all3ff, 5,   5,   1, d3,   1,  1,  all3ff};
    tbl[9]  = '{3, 0,   3,   0, 0,   f1,     3,   0,   1, d1,   1,  1,  d1};
    tbl[10] = '{3, 0,   3,   0, 0,   f1,     4,   0,   1, d1,   0,  0,  '0};
    tbl[11] = '{0, 10,  19,  5, 6,   f1,     12,  5,   1, d3,   1,  1,  d3};
    tbl[12] = '{0, 10,  19,  5, 6,   f1,     30,  5,   1, d3,   1,  0,  d3};
    tbl[13] = '{1, 20,  19,  0, 7,   f1,     20,  0,   1, d2,   1,  0,  f1};
    tbl[14] = '{0, 10,  19,  5, 6,   f1,     12,  5,   0, d3,   0,  0,  '0};
    tbl[15] = '{1, 10,  19,  5, 6,   f1,     30,  5,   0, d3,   0,  0,  '0};

    model_reset();
    do_reset();

    // Reset defaults: BLANK, window starts at column 256, fill 0.
    step(1'b1, 0, 0, d1, 1'b0);
    step(1'b1, 256, 0, d2, 1'b0);
    chk("def_fs_data", 64'(oDATA), 64'd0);
    chk("def_fs_dval", 64'(oDVAL), 64'd1);
    bubble();
    chk("def_256_data", 64'(oDATA), 64'(d2));
    chk("def_256_inwin", 64'(oIN_WIN), 64'd1);

    // Vector table: program, apply at FS, present pixel, read it 2 edges later.
    for (int i = 0; i < 16; i++) begin
      set_cfg(tbl[i].mode, tbl[i].hs, tbl[i].he, tbl[i].vs, tbl[i].ve, tbl[i].fill);
      step(1'b0, 1, 1, '0, 1'b1);
      step(1'b1, 0, 0, rand_pix(), 1'b0);
      step(tbl[i].dv, tbl[i].h, tbl[i].v, tbl[i].d, 1'b0);
      bubble();
      chk($sformatf("vec%0d_dval", i), 64'(oDVAL), 64'(tbl[i].xdv));
      chk($sformatf("vec%0d_inwin", i), 64'(oIN_WIN), 64'(tbl[i].xin));
      chk($sformatf("vec%0d_data", i), 64'(oDATA), 64'(tbl[i].xd));
    end

    // Mid-frame write stays pending; applied at the next FS.
    set_cfg(1, 0, 3, 0, 0, f1);
    step(1'b0, 1, 1, '0, 1'b1);
    set_cfg(1, 10, 19, 5, 6, f1);
    frame(24, 8, 30, 0);
    chk("mid_pend", 64'(oCFG_PEND), 64'd1);
    step(1'b1, 0, 0, rand_pix(), 1'b0);
    chk("mid_pend_clr", 64'(oCFG_PEND), 64'd0);
    chk("mid_wcnt_old", 64'(oWIN_CNT), 64'd4);
    frame(24, 8, -1, 1);
    step(1'b1, 0, 0, rand_pix(), 1'b0);
    chk("mid_wcnt_new", 64'(oWIN_CNT), 64'd20);

    // BORDER: a 4x4 window has a 12-pixel outline.
    set_cfg(2, 2, 5, 2, 5, all3ff);
    step(1'b0, 1, 1, '0, 1'b1);
    tgt_fill = all3ff; seen_fill = 0;
    frame(8, 8, -1, 0);
    bubble(); bubble();
    chk("border_edges", 64'(seen_fill), 64'd12);

    // DROP: only the 4 pixels of row 0, columns 0..3 survive.
    set_cfg(3, 0, 3, 0, 0, '0);
    step(1'b0, 1, 1, '0, 1'b1);
    seen_dval = 0;
    frame(8, 8, -1, 0);
    bubble(); bubble();
    chk("drop_valid", 64'(seen_dval), 64'd4);

    // Write coincident with FS: old pending applies, new one waits a frame.
    set_cfg(1, 0, 1, 0, 0, f1);
    step(1'b0, 1, 1, '0, 1'b1);
    set_cfg(1, 4, 7, 2, 3, f1);
    step(1'b1, 0, 0, rand_pix(), 1'b1);
    chk("coinc_pend", 64'(oCFG_PEND), 64'd1);
    frame(8, 8, -1, 1);
    step(1'b1, 0, 0, rand_pix(), 1'b0);
    chk("coinc_pend_clr", 64'(oCFG_PEND), 64'd0);
    chk("coinc_wcnt_old", 64'(oWIN_CNT), 64'd2);
    frame(8, 8, -1, 1);
    step(1'b1, 0, 0, rand_pix(), 1'b0);
    chk("coinc_wcnt_new", 64'(oWIN_CNT), 64'd8);

    // Empty window (H start above H end) counts nothing.
    set_cfg(1, 20, 19, 0, 7, f1);
    step(1'b0, 1, 1, '0, 1'b1);
    frame(24, 8, -1, 0);
    step(1'b1, 0, 0, rand_pix(), 1'b0);
    chk("empty_wcnt", 64'(oWIN_CNT), 64'd0);

    // Reset mid-line while pixels flow and a write is pending.
    set_cfg(0, 0, 23, 0, 7, f1);
    step(1'b0, 1, 1, '0, 1'b1);
    for (int x = 0; x < 8; x++) step(1'b1, x, 0, rand_pix(), 1'(x == 5));
    chk("pre_rst_dval", 64'(oDVAL), 64'd1);
    do_reset();
    for (int x = 8; x < 16; x++) step(1'b1, x, 0, rand_pix(), 1'b0);

    // Randomized frames with random config writes and bubbles.
    for (int f = 0; f < 10; f++) begin
      for (int y = 0; y < 6; y++) begin
        for (int x = 0; x < 16; x++) begin
          set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 17)),
                  int'($urandom_range(0, 17)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), rand_pix());
          step(1'($urandom_range(0, 9) != 0), x, y, rand_pix(),
               1'($urandom_range(0, 19) == 0));
        end
      end
    end
    bubble(); bubble();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_crop_window.md
# image_crop_window

Parametrised rectangular crop/window stage for the camera-to-VGA pixel path, sitting between the Bayer-to-RGB converter and the frame-buffer writer. Compares the incoming pixel coordinates against a runtime-programmable window. Depending on mode, it passes, blanks, outlines or drops pixels outside the window. Window changes are double-buffered and take effect only at a frame boundary, so no frame is ever torn.

## Interface
- DATA_W, 10, bits per colour channel
- NCH, 3, channel count; channel k occupies bits [k*DATA_W +: DATA_W], R = channel 0
- CNT_W, 13, width of coordinate counters and window bounds
- DEF_H_START, 256, reset value of active/pending H start
- DEF_H_END, 639, reset value of active/pending H end
- DEF_V_START, 0, reset value of active/pending V start
- DEF_V_END, 479, reset value of active/pending V end

Ports (one clock; reset is asynchronous and active-high):
- iCLK  in  1  pixel clock
- iRST  in  1  asynchronous, active-high reset
- iDVAL  in  1  input pixel valid
- iH_Cont  in  CNT_W  pixel column of the current input pixel
- iV_Cont  in  CNT_W  pixel row of the current input pixel
- iDATA  in  NCH*DATA_W  packed input pixel
- iCFG_WE  in  1  one-cycle strobe; captures the iH_START…iMODE inputs into the pending registers
- iH_START, iH_END, iV_START, iV_END  in  CNT_W each  window bounds, inclusive
- iMODE  in  2  0 BYPASS, 1 BLANK, 2 BORDER, 3 DROP
- iFILL  in  NCH*DATA_W  fill/border colour, pending-buffered like the bounds
- oDATA  out  NCH*DATA_W  output pixel
- oDVAL  out  1  output pixel valid
- oIN_WIN  out  1  output pixel lies inside the active window
- oCFG_PEND  out  1  pending configuration not yet applied
- oWIN_CNT  out  2*CNT_W  in-window valid-pixel count of the last completed frame

## Operation
- Frame start (FS): iDVAL=1 with iH_Cont=0 and iV_Cont=0.
- Config path:
  - iCFG_WE loads the pending registers and sets oCFG_PEND.
  - On FS, active <= pending and oCFG_PEND clears.
  - If iCFG_WE and FS occur in the same cycle, the old pending value is applied, the new value is captured into pending, and oCFG_PEND stays 1.
- In-window test: H_START ≤ iH_Cont ≤ H_END and V_START ≤ iV_Cont ≤ V_END, evaluated against the active config latched for this pixel. START > END on either axis means an empty window; no pixel is inside.
- BORDER edge: pixel is inside the window and iH_Cont ∈ {H_START, H_END} or iV_Cont ∈ {V_START, V_END}.
- Mode actions for a valid pixel:
  - BYPASS: data passes unchanged; oDVAL = iDVAL.
  - BLANK: inside passes; outside is replaced by FILL.
  - BORDER: edge pixels are replaced by FILL; all others pass.
  - DROP: inside passes; outside forces oDVAL=0 and oDATA=0.
- oIN_WIN is computed in every mode. When oDVAL=0, oDATA=0 and oIN_WIN=0.
- Pixel counter:
  - Counts valid in-window pixels; saturates at all-ones.
  - On FS, oWIN_CNT <= count, and the count restarts at 1 if the FS pixel is in-window, otherwise 0.
  - oWIN_CNT reads 0 until the first FS after reset.

## Timing
- Reset (async, asserted): oDATA=0, oDVAL=0, oIN_WIN=0, oCFG_PEND=0, oWIN_CNT=0, internal count=0. Active and pending config take the DEF_* bounds, mode BLANK, and FILL=0.
- Pipeline:
  - Stage 1 registers the data, iDVAL, the compare flags and the selected mode/fill.
  - Stage 2 registers the outputs.
  - Latency is exactly 2 cycles, with one pixel per clock and no back-pressure.
- The config applied at FS governs the FS pixel itself; the FS compare uses the freshly applied bounds (bypass mux in stage 1).
- iDVAL=0 cycles propagate as oDVAL=0 bubbles with the same 2-cycle latency.
- Reset asserted mid-frame: the pipeline is flushed immediately, and the first output after release is the pixel captured 2 cycles later.

## Structure
- Package image_crop_pkg holds:
  - Mode constants (MODE_BYPASS=0, MODE_BLANK=1, MODE_DROP=3, MODE_BORDER=2).
  - The default-bound localparams.
  - A function packing and unpacking channel k.
- Sub-module crop_window_cmp (combinational) takes coordinates plus bounds and returns in_win and on_edge. Instantiated once in stage 1.

## Test plan
- Reset defaults, BLANK, 640×480 ramp:
  - Column 255 -> FILL (0).
  - Column 256 -> pass, output 2 cycles after input.
  - Column 639 -> pass.
  - Column 640 -> 0.
  - Expected oWIN_CNT = 384×480 = 184320 after the second FS.
- Write H 10..19, V 5..6 mid-frame -> oCFG_PEND=1 and the current frame is unchanged. Next FS -> PEND=0 and window 10..19 × 5..6; oWIN_CNT after that frame = 20.
- BORDER, window 2..5 × 2..5, FILL=0x3FF all channels, 8×8 frame -> exactly 12 edge pixels = 0x3FF; interior 2×2 and outside pixels pass.
- DROP, window 0..3 × 0..0 -> oDVAL high for 4 pixels per frame only, and oDATA=0 whenever oDVAL=0.
- iCFG_WE coincident with FS -> old pending applied, new one pending (PEND=1), and applied at the following FS.
- iRST asserted for 1 cycle mid-line -> all outputs 0 within the same cycle; H_START=H_END+1 -> zero in-window pixels and oWIN_CNT=0.
